fifo_wr_arbiter: RTL

// - Round-robin arbiter sharing one fifo_v4 push port among NUM_REQ valid/ready requesters.
// - Sits in front of the shared W/R buffering FIFO in the crossbar.
// - Converts per-requester handshakes into push_i/data_i and uses full_o as backpressure.
// - Keeps grants fair: the last winner drops to lowest priority.

---
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO push port among NUM_REQ valid/ready requesters.
// Define FIFO_WR_ARBITER_LOCK_EN to keep a grant across a multi-beat burst until req_last_i.
module fifo_wr_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter type dtype   = logic [31:0],
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  dtype [NUM_REQ-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]    req_last_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_push_o,
    output dtype                  fifo_data_o,
    output logic                  gnt_valid_o,
    output logic [IDX_W-1:0]      gnt_idx_o
);

    logic [IDX_W-1:0] prio_q;
    logic [IDX_W-1:0] prio_d;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             push;

    // (base + off) mod NUM_REQ, valid for off < NUM_REQ
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    // Scan from the lowest priority back to prio_q so the last hit is the first valid in RR order.
    always_comb begin
        arb_idx = prio_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[rot_idx(prio_q, i)]) arb_idx = rot_idx(prio_q, i);
        end
    end

`ifdef FIFO_WR_ARBITER_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] lock_idx_d;

    assign gnt_idx = (state_q == LOCKED) ? lock_idx_q : arb_idx;
    assign gnt_vld = (state_q == LOCKED) ? req_valid_i[lock_idx_q] : |req_valid_i;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        prio_d     = prio_q;
        if (push) begin
            if (state_q == IDLE) begin
                if (req_last_i[gnt_idx]) begin
                    prio_d = wrap_inc(gnt_idx);
                end else begin
                    state_d    = LOCKED;
                    lock_idx_d = gnt_idx;
                end
            end else if (req_last_i[lock_idx_q]) begin
                state_d = IDLE;
                prio_d  = wrap_inc(lock_idx_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last_i;
    assign gnt_idx     = arb_idx;
    assign gnt_vld     = |req_valid_i;
    assign prio_d      = push ? wrap_inc(gnt_idx) : prio_q;
`endif

    // Full and flush both block the handshake; reset forces every output quiet.
    assign push = rst_ni & gnt_vld & req_valid_i[gnt_idx] & ~fifo_full_i & ~flush_i;

    always_comb begin
        req_ready_o          = '0;
        req_ready_o[gnt_idx] = push;
        fifo_push_o          = push;
        fifo_data_o          = req_data_i[gnt_idx];
        gnt_valid_o          = rst_ni & gnt_vld;
        gnt_idx_o            = rst_ni ? gnt_idx : '0;
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and is not in the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) prio_q <= '0;
        else                    prio_q <= prio_d;
    end

endmodule
